// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: captures packed BCD from the binary-to-BCD pipeline and
// scans it onto a common-anode 4-digit 7-segment display.
// Optional build macro: SEG_LZB_EN (leading-zero blanking of the upper digits).
module bcd_seg_scan #(
    parameter int unsigned CLK_DIV   = 50000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [16:0] bcd_in,
    input  logic        bcd_vld,
    output logic [6:0]  seg_n,
    output logic [3:0]  an_n,
    output logic        frame_done
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [15:0]      disp_reg;
    logic [CNT_W-1:0] div_cnt;
    logic [1:0]       idx;

    logic       slot_end_c;
    logic       blank_c;
    logic       lzb_c;
    logic [3:0] digit_c;
    logic [6:0] seg_c;
    logic       unused_rsvd;

    // Bit 16 is reserved in the pipeline format and deliberately ignored
    assign unused_rsvd = bcd_in[16];

    assign slot_end_c = (div_cnt == CNT_W'(CLK_DIV - 1));

    // Anti-ghost window at the start of each slot
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign blank_c = 1'b0;
        end else begin : g_blank
            assign blank_c = (div_cnt < CNT_W'(BLANK_CYC));
        end
    endgenerate

    // Select the nibble of the digit currently being scanned
    always_comb begin
        digit_c = disp_reg[3:0];
        case (idx)
            2'd0: digit_c = disp_reg[3:0];
            2'd1: digit_c = disp_reg[7:4];
            2'd2: digit_c = disp_reg[11:8];
            2'd3: digit_c = disp_reg[15:12];
            default: digit_c = disp_reg[3:0];
        endcase
    end

    // Leading-zero blanking: a slot is dark when it and everything above it is zero
    always_comb begin
        lzb_c = 1'b0;
`ifdef SEG_LZB_EN
        case (idx)
            2'd1: lzb_c = (disp_reg[15:4] == 12'd0);
            2'd2: lzb_c = (disp_reg[15:8] == 8'd0);
            2'd3: lzb_c = (disp_reg[15:12] == 4'd0);
            default: lzb_c = 1'b0;
        endcase
`endif
    end

    // Active-low {a..g} decode; non-decimal nibbles show a dash
    always_comb begin
        seg_c = 7'b1111110;
        case (digit_c)
            4'd0: seg_c = 7'b0000001;
            4'd1: seg_c = 7'b1001111;
            4'd2: seg_c = 7'b0010010;
            4'd3: seg_c = 7'b0000110;
            4'd4: seg_c = 7'b1001100;
            4'd5: seg_c = 7'b0100100;
            4'd6: seg_c = 7'b0100000;
            4'd7: seg_c = 7'b0001111;
            4'd8: seg_c = 7'b0000000;
            4'd9: seg_c = 7'b0000100;
            default: seg_c = 7'b1111110;
        endcase
        if (lzb_c) begin
            seg_c = 7'b1111111;
        end
    end

    // Display register: reloads on every valid cycle, otherwise holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_reg <= 16'd0;
        end else if (bcd_vld) begin
            disp_reg <= bcd_in[15:0];
        end
    end

    // Slot divider and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            idx     <= 2'd0;
        end else if (slot_end_c) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
        end else begin
            div_cnt <= div_cnt + CNT_W'(1);
        end
    end

    // Registered display drive and frame pulse from pre-edge scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_n      <= 7'b1111111;
            an_n       <= 4'b1111;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= seg_c;
            an_n       <= blank_c ? 4'b1111 : ~(4'b0001 << idx);
            frame_done <= slot_end_c && (idx == 2'd3);
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: directed plus randomized checks of bcd_seg_scan against
// a time-based reference model (slot and digit derived from edge count).
module tb_bcd_seg_scan;

    localparam int unsigned CLK_DIV   = 8;
    localparam int unsigned BLANK_CYC = 2;
    localparam int unsigned FRAME     = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [16:0] bcd_in = 17'd0;
    logic        bcd_vld = 1'b0;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic        frame_done;

    int          tests = 0;
    int          fails = 0;
    int          n = 0;
    logic [15:0] disp_m = 16'd0;
    logic [6:0]  seg_tab [16];

    always #5 clk = ~clk;

    bcd_seg_scan #(
        .CLK_DIV   (CLK_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .bcd_vld    (bcd_vld),
        .seg_n      (seg_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    // Expected segment pattern for digit position i of value d
    function automatic logic [6:0] exp_seg(input logic [15:0] d, input int i);
        logic [15:0] upper;
        upper = d >> (4 * i);
        exp_seg = seg_tab[upper[3:0]];
`ifdef SEG_LZB_EN
        if (i != 0 && upper == 16'd0) exp_seg = 7'b1111111;
`endif
    endfunction

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b (edge %0d)", tag, obs, expv, n);
        end
    endtask

    // One clock: drive inputs, predict outputs from pre-edge model state, compare
    task automatic step(input logic v, input logic [16:0] b);
        int c;
        int i;
        logic [3:0] ea;
        logic [6:0] es;
        logic ef;
        bcd_vld = v;
        bcd_in  = b;
        @(posedge clk);
        c  = n % CLK_DIV;
        i  = (n / CLK_DIV) % 4;
        ea = 4'hF;
        if (c >= BLANK_CYC) ea[i] = 1'b0;
        es = exp_seg(disp_m, i);
        ef = ((n % FRAME) == FRAME - 1);
        if (v) disp_m = b[15:0];
        n++;
        @(negedge clk);
        check("seg_n", seg_n, es);
        check("an_n", 7'(an_n), 7'(ea));
        check("frame_done", 7'(frame_done), 7'(ef));
    endtask

    function automatic logic [16:0] rand_bcd();
        logic [16:0] b;
        int sel;
        sel = int'($urandom_range(0, 3));
        b = 17'($urandom);
        if (sel != 0) begin
            for (int k = 0; k < 4; k++) b[4*k +: 4] = 4'($urandom_range(0, 9));
            if (sel == 2) b[15:8] = 8'd0;
            if (sel == 3) b[15:4] = 12'd0;
        end
        rand_bcd = b;
    endfunction

    initial begin
        logic v;
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b1111110, 7'b1111110,
                    7'b1111110, 7'b1111110, 7'b1111110, 7'b1111110};

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg_n", seg_n, 7'b1111111);
        check("rst_an_n", 7'(an_n), 7'b0001111);
        check("rst_frame_done", 7'(frame_done), 7'd0);
        rst_n = 1'b1;
        n = 0;
        disp_m = 16'd0;

        // Free scan with no valid: zeros everywhere, bcd_in ignored
        repeat (40) step(1'b0, 17'h1FFFF);

        // Single-cycle capture then hold
        step(1'b1, 17'h01023);
        repeat (40) step(1'b0, 17'($urandom));

        // Non-decimal nibbles show dashes
        step(1'b1, 17'h0AB5C);
        repeat (36) step(1'b0, 17'($urandom));

        // Capture on the last cycle of the units slot
        while ((n % FRAME) != CLK_DIV - 1) step(1'b0, 17'($urandom));
        step(1'b1, 17'h00009);
        repeat (40) step(1'b0, 17'($urandom));

        // Small value: leading positions zero
        step(1'b1, 17'h00007);
        repeat (36) step(1'b0, 17'($urandom));

        // Random captures, including multi-cycle valid bursts
        repeat (400) begin
            v = ($urandom_range(0, 7) == 0);
            step(v, rand_bcd());
        end
        repeat (5) step(1'b1, rand_bcd());

        // Asynchronous reset in the middle of the hundreds slot
        while ((n % FRAME) != 2 * CLK_DIV + 3) step(1'b0, 17'($urandom));
        bcd_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_seg_n", seg_n, 7'b1111111);
        check("async_rst_an_n", 7'(an_n), 7'b0001111);
        check("async_rst_frame_done", 7'(frame_done), 7'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        disp_m = 16'd0;
        repeat (40) step(1'b0, 17'($urandom));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Final consumer of the binary-to-BCD pipeline.
- Captures the packed BCD result when the last pipeline stage asserts valid, and holds it in a display register.
- Time-multiplexes the four digits onto a common-anode 4-digit 7-segment display with a programmable refresh rate and anti-ghost blanking.

Parameters:
- CLK_DIV, 50000: clocks per digit slot; legal range ≥ 4.
- BLANK_CYC, 2: clocks at the start of each slot with all anodes off; legal range 0 ≤ BLANK_CYC < CLK_DIV.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- bcd_in  input  17  packed BCD from the pipeline: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units; bit 16 reserved and ignored
- bcd_vld  input  1  bcd_in valid, single- or multi-cycle
- seg_n  output  7  segments {a,b,c,d,e,f,g}, active-low, registered
- an_n  output  4  digit anodes, active-low one-hot, registered; bit 0 = units, bit 3 = thousands
- frame_done  output  1  one-clock pulse when the scan wraps from digit 3 to digit 0

Behaviour:
- Reset values (async on rst_n low):
  - disp_reg = 0, div_cnt = 0, idx = 0
  - seg_n = 7'b1111111, an_n = 4'b1111, frame_done = 0
- Capture:
  - Every clk edge with bcd_vld = 1 loads disp_reg <= bcd_in[15:0]; no handshake back to the pipeline, input is never stalled.
  - bcd_vld held high reloads disp_reg every cycle.
  - bcd_vld low holds disp_reg indefinitely.
- Scan counter:
  - div_cnt counts 0..CLK_DIV-1 and wraps to 0.
  - On the edge where div_cnt == CLK_DIV-1: idx advances 0->1->2->3->0.
  - On the 3->0 transition frame_done = 1 for exactly that next cycle, else 0.
- Output register, updated every edge from the pre-edge values of div_cnt, idx and disp_reg:
  - an_n = 4'b1111 if div_cnt < BLANK_CYC, else ~(1<<idx).
  - seg_n = decode(digit[idx]), even during blanking.
- Decode, active-low, {a..g}:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110, 4 = 1001100
  - 5 = 0100100, 6 = 0100000, 7 = 0001111, 8 = 0000000, 9 = 0000100
  - any nibble 10-15 = 1111110 (dash, g only)
- Latency:
  - bcd_vld sampled at edge N updates disp_reg at edge N.
  - seg_n reflects the new value at edge N+1 if that digit is selected.
- Slot timing: with BLANK_CYC = 0, the anode is never all-off after reset; the first edge after reset release drives an_n = 1110.
- Simultaneous events:
  - A capture on the same edge as a digit change is legal and independent.
  - The new idx and new disp_reg are both used at the following edge.
- Reset mid-scan: all state returns to the reset values immediately; the scan restarts at digit 0 with div_cnt = 0.

Optional Feature:
- Macro: SEG_LZB_EN (leading-zero blanking).
- Defined:
  - Thousands slot is blanked (seg_n = 1111111) when disp_reg[15:12] == 0.
  - Hundreds slot is blanked when [15:8] == 0.
  - Tens slot is blanked when [15:4] == 0.
  - Units slot is always shown.
  - Anode timing is unchanged.
- Undefined: all four digits are always decoded, so 7 displays as 0007.

Test Plan (CLK_DIV = 8, BLANK_CYC = 2):
- Reset release, no vld:
  - an_n steps 1111 x2, 1110 x6, 1111 x2, 1101 x6, … through 0111.
  - seg_n = 0000001 on every enabled slot.
  - frame_done pulses once every 32 clocks.
- bcd_vld one cycle with bcd_in = 17'h01023:
  - Units slot shows 0000110 (3), tens shows 0010010 (2), hundreds shows 0000001 (0), thousands shows 1001111 (1).
  - Values persist after vld drops.
- bcd_vld asserted on the edge where div_cnt = 7 with idx = 0, bcd_in = 17'h00009:
  - Next edge: an_n = 1111 (blank), idx = 1.
  - Units shows 0000100 on its next slot.
- bcd_in = 17'h0AB5C with vld:
  - Thousands, hundreds and units show 1111110.
  - Tens shows 0100100 (5).
- SEG_LZB_EN defined, bcd_in = 17'h00007:
  - Thousands, hundreds and tens slots give seg_n = 1111111 while their anode is active.
  - Units gives 0001111.
  - Without the macro, the other slots show 0000001.
- rst_n pulsed low mid-slot at idx = 2:
  - seg_n = 1111111, an_n = 1111, frame_done = 0 asynchronously.
  - After release the scan restarts at idx 0 and disp_reg = 0.
